// File: rtl/mixed_wordline_responder_pkg.sv
// Shared sizing constants and types for the wordline responder and its storage.
package mixed_wordline_responder_pkg;

  localparam int BSIZE      = 10;
  localparam int BSIZE_LOG2 = 4;
  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [BSIZE_LOG2-1:0] addr_t;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ,
    RESP
  } rsp_state_t;

endpackage

// File: rtl/mixed_wordline_store.sv
// DEPTH x WIDTH wordline array with one write port and a registered synchronous read.
module mixed_wordline_store #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset here so the array maps onto block RAM; the responder clears it after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mixed_wordline_responder.sv
// Wordline request/response responder: clears storage after reset, then serves one request at a time.
// Optional stored parity with error injection when MIXED_WORDLINE_PARITY_EN is defined.
module mixed_wordline_responder
  import mixed_wordline_responder_pkg::*;
#(
  parameter int DATA_WIDTH = WORD_WIDTH,
  parameter int DEPTH      = BSIZE,
  parameter int ADDR_WIDTH = BSIZE_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef MIXED_WORDLINE_PARITY_EN
  input  logic                  par_inject,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  init_done
);

`ifdef MIXED_WORDLINE_PARITY_EN
  localparam int SW = DATA_WIDTH + 1;
`else
  localparam int SW = DATA_WIDTH;
`endif

  rsp_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  init_done_q, init_done_d;

  logic                  st_we, st_re;
  logic [ADDR_WIDTH-1:0] st_addr;
  logic [SW-1:0]         st_wdata, st_rdata;
  logic                  in_range;
  logic                  rd_bad;

  assign in_range = {1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH);

`ifdef MIXED_WORDLINE_PARITY_EN
  // Even parity: the stored bit equals the XOR of the data, optionally flipped to inject a fault.
  assign rd_bad = (^st_rdata[DATA_WIDTH-1:0]) != st_rdata[DATA_WIDTH];
`else
  assign rd_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    init_done_d = init_done_q;
    st_we       = 1'b0;
    st_re       = 1'b0;
    st_addr     = req_addr;
`ifdef MIXED_WORDLINE_PARITY_EN
    st_wdata    = {(^req_wdata) ^ par_inject, req_wdata};
`else
    st_wdata    = req_wdata;
`endif
    case (state_q)
      INIT: begin
        st_we    = 1'b1;
        st_addr  = cnt_q;
        st_wdata = '0;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          cnt_d       = '0;
          state_d     = IDLE;
          init_done_d = 1'b1;
          req_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (!in_range) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else if (req_write) begin
            st_we       = 1'b1;
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
          end else begin
            st_re   = 1'b1;
            state_d = READ;
          end
        end
      end
      READ: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = st_rdata[DATA_WIDTH-1:0];
        rsp_err_d   = rd_bad;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      init_done_q <= init_done_d;
    end
  end

  mixed_wordline_store #(
    .DEPTH (DEPTH),
    .WIDTH (SW),
    .AW    (ADDR_WIDTH)
  ) u_store (
    .clk   (clk),
    .we    (st_we),
    .re    (st_re),
    .addr  (st_addr),
    .wdata (st_wdata),
    .rdata (st_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_mixed_wordline_responder.sv
// Self-checking bench for mixed_wordline_responder; directed steps followed by random traffic
// compared against an array model. Exercises parity injection when MIXED_WORDLINE_PARITY_EN is defined.
module tb_mixed_wordline_responder;
  import mixed_wordline_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  addr_t       req_addr = '0;
  word_t       req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  word_t       rsp_data;
  logic        rsp_err;
  logic        init_done;
  logic        par_inject = 1'b0;

  int checks = 0;
  int errors = 0;

  word_t model_mem [16];
  bit    model_bad [16];

  always #5 clk = ~clk;

  mixed_wordline_responder dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MIXED_WORDLINE_PARITY_EN
    .par_inject(par_inject),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    int n;
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    check("rst_init_done", 32'(init_done), 0);
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = '0;
      model_bad[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!init_done) check("init_req_ready", 32'(req_ready), 0);
    end
    check("init_cycles", n, 10);
    check("init_ready_after", 32'(req_ready), 1);
    $display("reset: init_done after %0d cycles", n);
  endtask

  task automatic transact(input bit wr, input addr_t addr, input word_t data, input bit inj, input int hold);
    int    n;
    bit    in_range;
    bit    exp_err;
    word_t exp_data;
    int    exp_lat;
    in_range = addr < 4'd10;
    if (!in_range) begin
      exp_err = 1'b1; exp_data = '0; exp_lat = 1;
    end else if (wr) begin
      exp_err = 1'b0; exp_data = '0; exp_lat = 1;
      model_mem[addr] = data;
`ifdef MIXED_WORDLINE_PARITY_EN
      model_bad[addr] = inj;
`else
      model_bad[addr] = 1'b0;
`endif
    end else begin
      exp_err = model_bad[addr]; exp_data = model_mem[addr]; exp_lat = 2;
    end
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    par_inject = inj; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; par_inject = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("latency", n, exp_lat);
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("busy_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_data", rsp_data, exp_data);
      check("hold_err", 32'(rsp_err), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rsp_released", 32'(rsp_valid), 0);
    rsp_ready = 1'b0;
    $display("%s addr=%0d wdata=%h inj=%0d -> data=%h err=%0d lat=%0d hold=%0d",
             wr ? "WR" : "RD", addr, data, inj, exp_data, exp_err, n, hold);
  endtask

  initial begin
    #2;
    do_reset();

    for (int a = 0; a < 10; a++) transact(1'b0, addr_t'(a), '0, 1'b0, 0);

    transact(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 0);
    transact(1'b0, 4'd3, '0, 1'b0, 0);
    transact(1'b0, 4'd12, '0, 1'b0, 0);
    transact(1'b0, 4'd9, '0, 1'b0, 0);
    transact(1'b0, 4'd3, '0, 1'b0, 5);

    // Reset while a write response is pending.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd7; req_wdata = 32'h1234_5678; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_drop_rsp_valid", 32'(rsp_valid), 0);
    $display("mid-response reset applied");
    do_reset();
    transact(1'b0, 4'd3, '0, 1'b0, 0);
    transact(1'b0, 4'd7, '0, 1'b0, 0);

`ifdef MIXED_WORDLINE_PARITY_EN
    transact(1'b1, 4'd5, 32'h1, 1'b1, 0);
    transact(1'b0, 4'd5, '0, 1'b0, 0);
    transact(1'b1, 4'd5, 32'h3, 1'b0, 0);
    transact(1'b0, 4'd5, '0, 1'b0, 0);
`endif

    for (int k = 0; k < 150; k++) begin
      bit    wr;
      addr_t a;
      word_t d;
      bit    inj;
      wr  = 1'($urandom_range(0, 1));
      a   = addr_t'($urandom_range(0, 15));
      d   = $urandom;
`ifdef MIXED_WORDLINE_PARITY_EN
      inj = ($urandom_range(0, 7) == 0);
`else
      inj = 1'b0;
`endif
      transact(wr, a, d, inj, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
